input_port: RTL and testbench

Byte-wide input peripheral: the receiving counterpart of the CPU's `Out` register, carrying data from an external producer into the CPU. An external device pushes words through a valid/ready handshake into a small FIFO. The CPU drains the FIFO onto the bus under a control-word read strobe, qualified by `clk_en`. A non-empty flag is exported to the instruction decoder for conditional jumps (poll-until-data).

---
 rtl/input_port_pkg.sv | 16 +
 rtl/input_port_sync_fifo.sv | 59 +++++
 rtl/input_port.sv | 67 ++++++
 tb/tb_input_port.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/input_port_pkg.sv
// Shared types for the CPU input port: FIFO operation encoding used by the
// occupancy update in sync_fifo.
package input_port_pkg;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/input_port_sync_fifo.sv
// Synchronous FIFO: storage array, wrapping pointers and an occupancy count.
// Callers must only push when not full and only pop when not empty.
module sync_fifo
    import input_port_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1),
    localparam int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] count_next
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;

    // Storage is deliberately left out of reset; only pointers and count matter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        count_next = count;
        unique case (fifo_op(push, pop))
            FIFO_PUSH: count_next = count + 1'b1;
            FIFO_POP:  count_next = count - 1'b1;
            default:   count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/input_port.sv
// CPU input peripheral: producer-side valid/ready handshake into a FIFO that
// the CPU drains onto the bus with a clk_en-qualified read strobe.
module input_port
    import input_port_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   i_valid,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_ready,
    input  logic                   i_read,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_avail,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_underflow
);

    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

    logic                   push;
    logic                   pop;
    logic                   read_strobe;
    logic [WIDTH-1:0]       head;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;

    assign read_strobe = clk_en && i_read;
    assign push        = i_valid && o_ready;
    // A read against an empty FIFO never pops, even if a push lands the same edge.
    assign pop         = read_strobe && o_avail;

    sync_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (i_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .count_next(count_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ready     <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_ready <= (count_next < FULL_COUNT);
            if (read_strobe && !o_avail) begin
                o_underflow <= 1'b1;
            end
        end
    end

    assign o_avail = (count != '0);
    assign o_data  = o_avail ? head : '0;
    assign o_count = count;

endmodule

// File: tb/tb_input_port.sv
// Self-checking bench for input_port: directed test-plan scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_input_port;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clk_en;
    logic                   i_valid;
    logic [WIDTH-1:0]       i_data;
    logic                   o_ready;
    logic                   i_read;
    logic [WIDTH-1:0]       o_data;
    logic                   o_avail;
    logic [COUNT_WIDTH-1:0] o_count;
    logic                   o_underflow;

    input_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .i_read     (i_read),
        .o_data     (o_data),
        .o_avail    (o_avail),
        .o_count    (o_count),
        .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue, plus ready and sticky underflow.
    logic [WIDTH-1:0] m_q[$];
    logic             m_ready;
    logic             m_uf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic check_state(input string tag);
        logic [WIDTH-1:0] exp_data;
        exp_data = (m_q.size() != 0) ? m_q[0] : '0;
        chk({tag, ".ready"}, 32'(o_ready), 32'(m_ready));
        chk({tag, ".avail"}, 32'(o_avail), 32'(m_q.size() != 0));
        chk({tag, ".count"}, 32'(o_count), 32'(m_q.size()));
        chk({tag, ".data"}, 32'(o_data), 32'(exp_data));
        chk({tag, ".uf"}, 32'(o_underflow), 32'(m_uf));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ready = 1'b0;
        m_uf    = 1'b0;
    endtask

    // Advance one clock: apply the model to the inputs seen at the edge, then check.
    task automatic step(input string tag);
        logic accept;
        logic rd;
        @(posedge clk);
        accept = i_valid && m_ready;
        rd     = clk_en && i_read;
        if (rd) begin
            if (m_q.size() == 0) m_uf = 1'b1;
            else void'(m_q.pop_front());
        end
        if (accept) m_q.push_back(i_data);
        m_ready = (m_q.size() < DEPTH);
        #1;
        check_state(tag);
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0;
        i_data  = '0;
        i_read  = 1'b0;
        clk_en  = 1'b0;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d, input string tag);
        i_valid = 1'b1;
        i_data  = d;
        step(tag);
        i_valid = 1'b0;
    endtask

    task automatic pop_word(input string tag);
        clk_en = 1'b1;
        i_read = 1'b1;
        step(tag);
        clk_en = 1'b0;
        i_read = 1'b0;
    endtask

    // Assert reset between edges, check outputs clear at once, release on negedge.
    task automatic async_reset(input string tag);
        #2;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("release");
        chk("release_ready", 32'(o_ready), 32'd1);

        // Single word
        push_word(8'hA5, "single_push");
        chk("single_data", 32'(o_data), 32'hA5);
        pop_word("single_pop");
        chk("single_empty_data", 32'(o_data), 32'h00);

        // Fill and wrap
        for (int i = 1; i <= 4; i++) push_word(8'(i), "fill");
        chk("fill_count", 32'(o_count), 32'd4);
        chk("fill_ready", 32'(o_ready), 32'd0);
        i_valid = 1'b1;
        i_data  = 8'h05;
        step("full_hold0");
        step("full_hold1");
        chk("full_hold_count", 32'(o_count), 32'd4);
        clk_en = 1'b1;
        i_read = 1'b1;
        step("full_pop");
        chk("full_pop_ready", 32'(o_ready), 32'd1);
        clk_en = 1'b0;
        i_read = 1'b0;
        step("accept_05");
        i_valid = 1'b0;
        chk("accept_05_count", 32'(o_count), 32'd4);
        for (int i = 2; i <= 5; i++) begin
            chk("drain_order", 32'(o_data), 32'(i));
            pop_word("drain");
        end

        // clk_en gating
        push_word(8'h11, "gate_push0");
        push_word(8'h22, "gate_push1");
        i_read = 1'b1;
        for (int i = 0; i < 3; i++) step("gate_hold");
        chk("gate_count", 32'(o_count), 32'd2);
        clk_en = 1'b1;
        step("gate_pulse");
        clk_en = 1'b0;
        i_read = 1'b0;
        chk("gate_pulse_count", 32'(o_count), 32'd1);
        chk("gate_pulse_data", 32'(o_data), 32'h22);
        pop_word("gate_drain");

        // Empty read race
        i_valid = 1'b1;
        i_data  = 8'h3C;
        clk_en  = 1'b1;
        i_read  = 1'b1;
        step("race");
        idle_inputs();
        chk("race_uf", 32'(o_underflow), 32'd1);
        chk("race_count", 32'(o_count), 32'd1);
        chk("race_data", 32'(o_data), 32'h3C);

        // Mid-stream reset
        push_word(8'h44, "mid_push0");
        push_word(8'h55, "mid_push1");
        chk("mid_count", 32'(o_count), 32'd3);
        async_reset("mid_reset");
        step("mid_release");
        push_word(8'h77, "mid_new");
        chk("mid_new_data", 32'(o_data), 32'h77);
        pop_word("mid_new_pop");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            i_valid = ($urandom_range(0, 99) < 60);
            i_data  = 8'($urandom);
            i_read  = ($urandom_range(0, 99) < 55);
            clk_en  = ($urandom_range(0, 99) < 70);
            step("rand");
            if ($urandom_range(0, 999) == 0) async_reset("rand_reset");
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
